inst_rom_arbiter: RTL and testbench

//  Shares the single inst_rom read port between the openmips fetch port and a

---
 rtl/inst_rom_arbiter_pkg.sv | 23 ++
 rtl/inst_rom_arbiter.sv | 128 ++++++++++++
 tb/tb_inst_rom_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_arbiter_pkg
//  Description : Shared types and default widths for the inst_rom arbiter
//                (CPU fetch port vs. debug/display reader).
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_rom_arbiter_pkg;

  // Default widths, matching the openmips instruction bus definitions
  localparam int ARB_ADDR_W_DEF     = 32;
  localparam int ARB_DATA_W_DEF     = 32;
  localparam int ARB_STARVE_MAX_DEF = 8;
  localparam int ARB_CNT_W_DEF      = 4;

  // Arbiter state: one bit, CPU owns the port unless a debug slot is running
  typedef enum logic [0:0] {
    S_CPU = 1'b0,
    S_DBG = 1'b1
  } arb_state_t;

endpackage : inst_rom_arbiter_pkg
`default_nettype wire

// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_arbiter
//  Description : Shares the single inst_rom read port between the openmips
//                fetch port and a debug/display reader. The CPU has priority;
//                a starvation counter forces one debug slot (one CPU stall
//                cycle) after STARVE_MAX-1 blocked cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W_DEF,
  parameter int DATA_W     = ARB_DATA_W_DEF,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF,
  parameter int CNT_W      = ARB_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // CPU fetch port
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              cpu_stall_o,
  // Debug read port
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_data_o,
  // inst_rom port
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_MAX - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic [ADDR_W-1:0] r_dbg_addr;
  logic [ADDR_W-1:0] w_dbg_addr_nxt;

  // A live request is one that is not in its ack cycle (req is ignored there)
  logic w_pending;
  logic w_starved;
  logic w_take;

  assign w_pending = dbg_req_i & ~dbg_ack_o;
  assign w_starved = (r_starve_cnt == c_starve_limit);
  assign w_take    = w_pending & (~cpu_ce_i | w_starved);

  // State, starvation counter and latched debug address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_CPU;
      r_starve_cnt <= '0;
      r_dbg_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_dbg_addr   <= w_dbg_addr_nxt;
    end
  end

  // Next-state logic and ROM port steering
  always_comb begin
    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve_cnt;
    w_dbg_addr_nxt = r_dbg_addr;
    rom_ce_o       = 1'b0;
    rom_addr_o     = '0;
    cpu_inst_o     = '0;
    cpu_stall_o    = 1'b0;

    if (rst) begin
      // Keep the ROM port and the CPU interface quiet while in reset
      w_state_nxt = S_CPU;
    end else begin
      unique case (r_state)
        S_CPU: begin
          rom_ce_o   = cpu_ce_i;
          rom_addr_o = cpu_addr_i;
          cpu_inst_o = rom_data_i;
          if (w_take) begin
            w_state_nxt    = S_DBG;
            w_dbg_addr_nxt = dbg_addr_i;
            w_starve_nxt   = '0;
          end else if (w_pending) begin
            // Blocked by a CPU fetch: count the lost cycle, never wrap
            if (r_starve_cnt != {CNT_W{1'b1}}) begin
              w_starve_nxt = r_starve_cnt + CNT_W'(1);
            end
          end else if (!dbg_req_i) begin
            w_starve_nxt = '0;
          end
        end
        S_DBG: begin
          // One-cycle debug slot; a fetching CPU gets a NOP and holds its PC
          rom_ce_o    = 1'b1;
          rom_addr_o  = r_dbg_addr;
          cpu_inst_o  = '0;
          cpu_stall_o = cpu_ce_i;
          w_state_nxt = S_CPU;
        end
        default: begin
          w_state_nxt = S_CPU;
        end
      endcase
    end
  end

  // Debug return path: capture ROM word during the slot, pulse ack after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_ack_o  <= 1'b0;
      dbg_data_o <= '0;
    end else begin
      dbg_ack_o <= (r_state == S_DBG);
      if (r_state == S_DBG) begin
        dbg_data_o <= rom_data_i;
      end
    end
  end

endmodule : inst_rom_arbiter
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_rom_arbiter
//  Description : Self-checking bench for inst_rom_arbiter with a ROM model and
//                a cycle-level reference of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_arbiter;

  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_inst_o;
  logic        cpu_stall_o;
  logic        dbg_req_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_data_o;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  logic [31:0] rom [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is the next cycle a debug slot, its address, ack/data
  bit          m_slot;
  bit          m_ack;
  logic [31:0] m_slot_addr;
  logic [31:0] m_data;
  int          m_wait;

  // Values observed in the most recent step
  logic obs_stall;
  logic obs_ack;

  inst_rom_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM), .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_inst_o (cpu_inst_o),
    .cpu_stall_o(cpu_stall_o),
    .dbg_req_i  (dbg_req_i),
    .dbg_addr_i (dbg_addr_i),
    .dbg_ack_o  (dbg_ack_o),
    .dbg_data_o (dbg_data_o),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i)
  );

  always #5 clk = ~clk;

  assign rom_data_i = rom[rom_addr_o[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot      = 1'b0;
    m_ack       = 1'b0;
    m_slot_addr = '0;
    m_data      = '0;
    m_wait      = 0;
  endtask

  // One clock cycle: drive, check against model, advance model at the edge.
  // Entered and left at posedge+1.
  task automatic step(input logic ce, input logic [31:0] ca,
                      input logic req, input logic [31:0] da);
    logic        e_ce, e_stall, was_ack;
    logic [31:0] e_addr, e_inst;
    cpu_ce_i   = ce;
    cpu_addr_i = ca;
    dbg_req_i  = req;
    dbg_addr_i = da;
    #1;
    if (m_slot) begin
      e_ce = 1'b1; e_addr = m_slot_addr; e_inst = 32'h0; e_stall = ce;
    end else begin
      e_ce = ce; e_addr = ca; e_inst = rom[ca[7:2]]; e_stall = 1'b0;
    end
    chk("rom_ce",    {31'b0, rom_ce_o},    {31'b0, e_ce});
    chk("rom_addr",  rom_addr_o,           e_addr);
    chk("cpu_inst",  cpu_inst_o,           e_inst);
    chk("cpu_stall", {31'b0, cpu_stall_o}, {31'b0, e_stall});
    chk("dbg_ack",   {31'b0, dbg_ack_o},   {31'b0, m_ack});
    chk("dbg_data",  dbg_data_o,           m_data);
    obs_stall = cpu_stall_o;
    obs_ack   = dbg_ack_o;
    @(posedge clk);
    // A request is served in the first cycle the CPU is idle, or once it has
    // been blocked STARVE_MAX-1 times; ack/data appear the cycle after.
    was_ack = m_ack;
    m_ack   = m_slot;
    if (m_slot) begin
      m_data = rom[m_slot_addr[7:2]];
      m_slot = 1'b0;
    end else if (req && !was_ack) begin
      if (!ce || m_wait >= SM - 1) begin
        m_slot      = 1'b1;
        m_slot_addr = da;
        m_wait      = 0;
      end else begin
        m_wait++;
      end
    end else if (!req) begin
      m_wait = 0;
    end
    #1;
  endtask

  initial begin
    int acks, rs, cyc;
    bit pend, prev_stall, rq, ce;
    logic [31:0] da;

    for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | (i * 32'h0101_0011);
    rom[4] = 32'h3401_1100;

    // 1. Reset for 3 clocks with busy inputs; outputs must stay quiet
    rst = 1'b1; cpu_ce_i = 1'b1; cpu_addr_i = 32'h8; dbg_req_i = 1'b1; dbg_addr_i = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_ce",    {31'b0, rom_ce_o},    32'h0);
    chk("rst_rom_addr",  rom_addr_o,           32'h0);
    chk("rst_cpu_inst",  cpu_inst_o,           32'h0);
    chk("rst_cpu_stall", {31'b0, cpu_stall_o}, 32'h0);
    chk("rst_dbg_ack",   {31'b0, dbg_ack_o},   32'h0);
    chk("rst_dbg_data",  dbg_data_o,           32'h0);
    rst = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b0, 32'h0);

    // 2. Idle CPU debug read: slot in N+1, ack with data in N+2, single pulse
    step(1'b0, 32'h0, 1'b1, 32'h10);
    step(1'b0, 32'h0, 1'b1, 32'h10);
    step(1'b0, 32'h0, 1'b1, 32'h10);
    chk("t2_ack", {31'b0, obs_ack}, 32'h1);
    chk("t2_data_word", dbg_data_o, 32'h3401_1100);
    step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t2_single_pulse", {31'b0, obs_ack}, 32'h0);

    // 3. Continuous fetch, request at cycle 0: stall only in cycle 8, ack in 9
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'(i * 4), (i <= 9), 32'h20);
      chk("t3_stall", {31'b0, obs_stall}, {31'b0, (i == 8)});
      chk("t3_ack",   {31'b0, obs_ack},   {31'b0, (i == 9)});
    end
    chk("t3_data", dbg_data_o, rom[8]);

    // 4. Request held high: two acks in six cycles, never adjacent
    acks = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 1'b1, 32'h44);
      if (obs_ack) acks++;
      chk("t4_no_adjacent_ack", {31'b0, obs_ack & prev_stall}, 32'h0);
      prev_stall = obs_ack;
    end
    chk("t4_ack_count", 32'(acks), 32'd2);
    step(1'b0, 32'h0, 1'b0, 32'h0);

    // 5. Reset pulsed during the debug slot: no ack, data cleared
    step(1'b0, 32'h0, 1'b1, 32'h40);
    rst = 1'b1;
    #1;
    chk("t5_rst_rom_ce", {31'b0, rom_ce_o},  32'h0);
    chk("t5_rst_ack",    {31'b0, dbg_ack_o}, 32'h0);
    chk("t5_rst_data",   dbg_data_o,         32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t5_no_ack", {31'b0, obs_ack}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'h48);
    step(1'b0, 32'h0, 1'b1, 32'h48);
    step(1'b0, 32'h0, 1'b0, 32'h48);
    chk("t5_served", {31'b0, obs_ack}, 32'h1);
    chk("t5_data", dbg_data_o, rom[18]);

    // 6. Plain fetch stream, no debug
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 32'h0);
      chk("t6_stall", {31'b0, obs_stall}, 32'h0);
    end

    // 7. Randomized traffic against the model, plus latency/stall properties
    pend = 1'b0; rs = 0; da = 32'h0; prev_stall = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      ce = ($urandom_range(0, 3) != 0);
      if (pend && (dbg_ack_o || (cyc - rs) > SM + 1)) begin
        chk("rnd_latency", {31'b0, ((cyc - rs) <= SM + 1)}, 32'h1);
        pend = 1'b0;
        rq = 1'($urandom_range(0, 1));
      end else if (dbg_ack_o) begin
        rq = 1'($urandom_range(0, 1));
      end else if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1; rs = cyc; da = $urandom; rq = 1'b1;
      end else begin
        rq = pend;
      end
      step(ce, $urandom, rq, da);
      chk("rnd_no_double_stall", {31'b0, prev_stall & obs_stall}, 32'h0);
      prev_stall = obs_stall;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_inst_rom_arbiter
`default_nettype wire
